// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit_if
// Description : ID-stage hazard inputs and EX-stage forwarding and stall
//               outputs of fwd_hazard_unit, bundled as one interface.
//               The master side presents ID fields and flush.
//               The slave side returns the forwarding selects and stall.
// Revision    : 1.0  initial release
// ============================================================================
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic                  id_rt_used_i;
  logic [REG_ADDR_W-1:0] id_dst_i;
  logic                  id_regwrite_i;
  logic                  id_memread_i;
  logic                  flush_i;
  logic [1:0]            forward_a_o;
  logic [1:0]            forward_b_o;
  logic                  stall_o;

  modport master (
    output id_rs_i, id_rt_i, id_rt_used_i, id_dst_i,
           id_regwrite_i, id_memread_i, flush_i,
    input  forward_a_o, forward_b_o, stall_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_rt_used_i, id_dst_i,
           id_regwrite_i, id_memread_i, flush_i,
    output forward_a_o, forward_b_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Generates the EX-stage operand forwarding selects and the
//               load-use stall for a 5-stage pipeline. It tracks the
//               destination register of the instructions in EX, MEM and WB.
//               The selects are registered into EX with the instruction.
//                 00 = register file, 01 = MEM/WB, 10 = EX/MEM
//               Optional macro FWD_PERF_CNT_EN adds stall and forward counters.
// Revision    : 1.0  initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fwd_hazard_unit_if.slave    bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    fwd_cnt_o
`endif
);

  // Pipeline tracking slots
  logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic                  ex_we_q, ex_we_d;
  logic                  ex_mr_q, ex_mr_d;
  logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
  logic                  mem_we_q, mem_we_d;
  logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic                  wb_we_q, wb_we_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;

  logic                  stall;
  logic                  bubble;
  logic [1:0]            sel_a;
  logic [1:0]            sel_b;

  // The WB result reaches EX through the register file, so nothing here
  // reads the WB slot. It is kept so the full pipeline occupancy is tracked.
  logic unused_wb;
  assign unused_wb = ^{wb_dst_q, wb_we_q};

  // Load-use detection and select computation from the pre-edge slots.
  always_comb begin
    stall = 1'b0;
    sel_a = 2'b00;
    sel_b = 2'b00;

    if (ex_mr_q && ex_we_q && (ex_dst_q != '0) &&
        ((ex_dst_q == bus.id_rs_i) ||
         (bus.id_rt_used_i && (ex_dst_q == bus.id_rt_i))))
      stall = ~bus.flush_i & ~rst_i;

    // The EX producer is the most recent writer, so it wins over MEM.
    if ((bus.id_rs_i != '0) && ex_we_q && (ex_dst_q == bus.id_rs_i))
      sel_a = 2'b10;
    else if ((bus.id_rs_i != '0) && mem_we_q && (mem_dst_q == bus.id_rs_i))
      sel_a = 2'b01;

    if (bus.id_rt_used_i && (bus.id_rt_i != '0) && ex_we_q &&
        (ex_dst_q == bus.id_rt_i))
      sel_b = 2'b10;
    else if (bus.id_rt_used_i && (bus.id_rt_i != '0) && mem_we_q &&
             (mem_dst_q == bus.id_rt_i))
      sel_b = 2'b01;
  end

  // Next-state logic: advance the slots, and insert a bubble into EX on flush or stall.
  always_comb begin
    bubble    = bus.flush_i | stall;
    wb_dst_d  = mem_dst_q;
    wb_we_d   = mem_we_q;
    mem_dst_d = ex_dst_q;
    mem_we_d  = ex_we_q;
    ex_dst_d  = '0;
    ex_we_d   = 1'b0;
    ex_mr_d   = 1'b0;
    fwd_a_d   = 2'b00;
    fwd_b_d   = 2'b00;
    if (!bubble) begin
      ex_dst_d = bus.id_dst_i;
      ex_we_d  = bus.id_regwrite_i;
      ex_mr_d  = bus.id_memread_i;
      fwd_a_d  = sel_a;
      fwd_b_d  = sel_b;
    end
  end

  // Slot and select registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_dst_q  <= '0;
      ex_we_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      mem_dst_q <= '0;
      mem_we_q  <= 1'b0;
      wb_dst_q  <= '0;
      wb_we_q   <= 1'b0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
    end else begin
      ex_dst_q  <= ex_dst_d;
      ex_we_q   <= ex_we_d;
      ex_mr_q   <= ex_mr_d;
      mem_dst_q <= mem_dst_d;
      mem_we_q  <= mem_we_d;
      wb_dst_q  <= wb_dst_d;
      wb_we_q   <= wb_we_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  assign bus.forward_a_o = fwd_a_q;
  assign bus.forward_b_o = fwd_b_q;
  assign bus.stall_o     = stall;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Event counters: one count per stalled edge, and one per forwarding edge
  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
    fwd_cnt_d   = fwd_cnt_q +
                  {{(CNT_W-1){1'b0}}, (~bubble & ((sel_a != 2'b00) | (sel_b != 2'b00)))};
  end

  // Counter registers, cleared by reset and wrapping naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  // CNT_W only sizes the optional counters
  localparam int unsigned c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit. It drives a table
//               of ID-stage instructions and checks stall in the same cycle.
//               It queues the expected selects and compares them after the
//               next edge. It also runs a hand-written reset-during-stall
//               sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fwd_hazard_unit_if #(.REG_ADDR_W(5)) bus ();

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  int          exp_stall_cnt = 0;
  int          exp_fwd_cnt   = 0;
`endif

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .fwd_cnt_o   (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_used;
    logic [4:0] dst;
    logic       we;
    logic       mr;
    logic       fl;
    logic       exp_stall;
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input int rs, input int rt, input bit used, input int dst,
                         input bit we, input bit mr, input bit fl,
                         input bit st, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rt_used = used; v.dst = 5'(dst);
    v.we = we; v.mr = mr; v.fl = fl;
    v.exp_stall = st; v.exp_fa = fa; v.exp_fb = fb;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.id_rs_i       = v.rs;
    bus.id_rt_i       = v.rt;
    bus.id_rt_used_i  = v.rt_used;
    bus.id_dst_i      = v.dst;
    bus.id_regwrite_i = v.we;
    bus.id_memread_i  = v.mr;
    bus.flush_i       = v.fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       idle;
    logic [3:0] e;

    idle = '{default: '0};
    drive(idle);
    rst = 1'b1;

    //        rs rt used dst we mr fl | stall fa     fb
    // add $3 <- $1,$2 ; sub $4 <- $3,$5 : EX/MEM forward on A
    add_vec(1,  2, 1, 3,  1, 0, 0,   0, 2'b00, 2'b00);
    add_vec(3,  5, 1, 4,  1, 0, 0,   0, 2'b10, 2'b00);
    add_vec(0,  0, 0, 0,  0, 0, 0,   0, 2'b00, 2'b00);
    // add $3 ; nop ; or $6 <- $7,$3 : MEM/WB forward on B
    add_vec(1,  2, 1, 3,  1, 0, 0,   0, 2'b00, 2'b00);
    add_vec(0,  0, 0, 0,  0, 0, 0,   0, 2'b00, 2'b00);
    add_vec(7,  3, 1, 6,  1, 0, 0,   0, 2'b00, 2'b01);
    // lw $8 ; add $9 <- $8,$8 : one stall, then 01/01
    add_vec(1,  8, 0, 8,  1, 1, 0,   0, 2'b00, 2'b00);
    add_vec(8,  8, 1, 9,  1, 0, 0,   1, 2'b00, 2'b00);
    add_vec(8,  8, 1, 9,  1, 0, 0,   0, 2'b01, 2'b01);
    // add $0 ; reader of $0 : never forwarded
    add_vec(1,  2, 1, 0,  1, 0, 0,   0, 2'b00, 2'b00);
    add_vec(0,  0, 1, 10, 1, 0, 0,   0, 2'b00, 2'b00);
    // add $5 ; add $5 ; reader of $5 : EX/MEM wins
    add_vec(1,  1, 1, 5,  1, 0, 0,   0, 2'b00, 2'b00);
    add_vec(2,  2, 1, 5,  1, 0, 0,   0, 2'b00, 2'b00);
    add_vec(5,  5, 1, 11, 1, 0, 0,   0, 2'b10, 2'b10);
    // lw $12 ; flushed dependent ; target reads $12 from MEM/WB
    add_vec(1,  12, 0, 12, 1, 1, 0,  0, 2'b00, 2'b00);
    add_vec(12, 0, 1, 13, 1, 0, 1,   0, 2'b00, 2'b00);
    add_vec(12, 12, 1, 14, 1, 0, 0,  0, 2'b01, 2'b01);
    // lw $15 ; rt matches but is unused : no stall
    add_vec(0,  15, 0, 15, 1, 1, 0,  0, 2'b00, 2'b00);
    add_vec(1,  15, 0, 0,  0, 0, 0,  0, 2'b00, 2'b00);
    add_vec(2,  15, 1, 16, 1, 0, 0,  0, 2'b00, 2'b01);
    // lw $17 ; reader through rt : stall, then 00/01
    add_vec(0,  17, 0, 17, 1, 1, 0,  0, 2'b00, 2'b00);
    add_vec(1,  17, 1, 18, 1, 0, 0,  1, 2'b00, 2'b00);
    add_vec(1,  17, 1, 18, 1, 0, 0,  0, 2'b00, 2'b01);
    add_vec(0,  0, 0, 0,  0, 0, 0,   0, 2'b00, 2'b00);

    // Reset for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_fwd_a", 0, 32'(bus.forward_a_o), 32'h0);
    check("reset_fwd_b", 0, 32'(bus.forward_b_o), 32'h0);
    check("reset_stall", 0, 32'(bus.stall_o), 32'h0);
`ifdef FWD_PERF_CNT_EN
    check("reset_stall_cnt", 0, stall_cnt, 32'h0);
    check("reset_fwd_cnt", 0, fwd_cnt, 32'h0);
`endif
    rst = 1'b0;

    // Table: stall checked before the edge, selects checked after it
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check("stall", i, 32'(bus.stall_o), 32'(vecs[i].exp_stall));
      exp_q.push_back({vecs[i].exp_fa, vecs[i].exp_fb});
`ifdef FWD_PERF_CNT_EN
      if (vecs[i].exp_stall) exp_stall_cnt++;
      if ((vecs[i].exp_fa != 2'b00) || (vecs[i].exp_fb != 2'b00)) exp_fwd_cnt++;
`endif
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("fwd_a", i, 32'(bus.forward_a_o), 32'(e[3:2]));
      check("fwd_b", i, 32'(bus.forward_b_o), 32'(e[1:0]));
`ifdef FWD_PERF_CNT_EN
      check("stall_cnt", i, stall_cnt, 32'(exp_stall_cnt));
      check("fwd_cnt", i, fwd_cnt, 32'(exp_fwd_cnt));
`endif
      @(negedge clk);
    end

    // Reset while a load-use stall is pending
    drive('{rs: 5'd1, rt: 5'd20, rt_used: 1'b0, dst: 5'd20, we: 1'b1, mr: 1'b1,
            fl: 1'b0, exp_stall: 1'b0, exp_fa: 2'b00, exp_fb: 2'b00});
    @(posedge clk);
    @(negedge clk);
    drive('{rs: 5'd20, rt: 5'd0, rt_used: 1'b1, dst: 5'd21, we: 1'b1, mr: 1'b0,
            fl: 1'b0, exp_stall: 1'b0, exp_fa: 2'b00, exp_fb: 2'b00});
    #1;
    check("midstall_stall", 0, 32'(bus.stall_o), 32'h1);
    rst = 1'b1;
    #1;
    check("midstall_rst_stall", 0, 32'(bus.stall_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_stall", 0, 32'(bus.stall_o), 32'h0);
    check("postrst_fwd_a", 0, 32'(bus.forward_a_o), 32'h0);
    @(posedge clk);
    #1;
    check("postrst_fwd_a", 1, 32'(bus.forward_a_o), 32'h0);
    check("postrst_fwd_b", 1, 32'(bus.forward_b_o), 32'h0);
`ifdef FWD_PERF_CNT_EN
    check("postrst_stall_cnt", 0, stall_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
